// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : keypad_scanner                                               |
// | Description : Row-scanning front end for a 6x4 calculator keypad. Drives   |
// |               one active-low row at a time and synchronises the            |
// |               active-low columns. It classifies every full scan frame as   |
// |               NONE, SINGLE(k) or MULTI, debounces presses and releases     |
// |               over DEBOUNCE_SCANS frames, and emits a one-clock newkey     |
// |               pulse carrying the 5-bit calculator keycode.                 |
// | Ports       : clock    - system clock                                      |
// |               reset    - asynchronous active-low reset                     |
// |               col_n    - [3:0] matrix columns, active-low, asynchronous    |
// |               row_n    - [5:0] row drive, active-low, one-cold             |
// |               newkey   - one-cycle pulse on each accepted press            |
// |               keycode  - [4:0] code of last accepted key                   |
// |               key_held - high from accept until release is debounced       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [5:0] row_n,
  output logic       newkey,
  output logic [4:0] keycode,
  output logic       key_held
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                  c_SCAN_W   = $clog2(SCAN_DIV);
  localparam int                  c_CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_SAT   = c_CNT_W'(DEBOUNCE_SCANS);
  localparam logic [2:0]          c_ROW_LAST  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Matrix position (4*row + col) to calculator keycode
  // --------------------------------------------------------------------------
  function automatic logic [4:0] f_keymap(input logic [4:0] i_pos);
    logic [4:0] v_code;
    case (i_pos)
      5'd0:    v_code = 5'b10001;  // 1
      5'd1:    v_code = 5'b10010;  // 2
      5'd2:    v_code = 5'b10011;  // 3
      5'd3:    v_code = 5'b11010;  // A
      5'd4:    v_code = 5'b10100;  // 4
      5'd5:    v_code = 5'b10101;  // 5
      5'd6:    v_code = 5'b10110;  // 6
      5'd7:    v_code = 5'b11011;  // B
      5'd8:    v_code = 5'b10111;  // 7
      5'd9:    v_code = 5'b11000;  // 8
      5'd10:   v_code = 5'b11001;  // 9
      5'd11:   v_code = 5'b11100;  // C
      5'd12:   v_code = 5'b10000;  // 0
      5'd13:   v_code = 5'b11111;  // F
      5'd14:   v_code = 5'b11110;  // E
      5'd15:   v_code = 5'b11101;  // D
      5'd16:   v_code = 5'b01001;  // add
      5'd17:   v_code = 5'b01010;  // multiply
      5'd18:   v_code = 5'b01011;  // subtract
      5'd19:   v_code = 5'b01100;  // square
      5'd20:   v_code = 5'b00001;  // CE
      5'd21:   v_code = 5'b00010;  // DEL
      5'd22:   v_code = 5'b00011;  // CA
      5'd23:   v_code = 5'b00100;  // equals
      default: v_code = 5'b00000;
    endcase
    return v_code;
  endfunction

  // --------------------------------------------------------------------------
  // Column synchroniser (two flops, idle-high)
  // --------------------------------------------------------------------------
  logic [3:0] r_col_meta;
  logic [3:0] r_col_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_col_meta <= 4'b1111;
      r_col_sync <= 4'b1111;
    end else begin
      r_col_meta <= col_n;
      r_col_sync <= r_col_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Row scan timing
  // --------------------------------------------------------------------------
  logic [c_SCAN_W-1:0] r_scan_cnt;
  logic [2:0]          r_row_idx;
  logic [5:0]          r_row_n;
  logic                w_sample;
  logic                w_frame_end;

  // Columns are sampled on the last count of a row, giving the synchroniser
  // time to settle after the row drive changed.
  assign w_sample    = (r_scan_cnt == c_SCAN_LAST);
  assign w_frame_end = w_sample && (r_row_idx == c_ROW_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_scan_cnt <= '0;
      r_row_idx  <= 3'd0;
      r_row_n    <= 6'b111110;
    end else if (w_sample) begin
      r_scan_cnt <= '0;
      if (r_row_idx == c_ROW_LAST) begin
        r_row_idx <= 3'd0;
        r_row_n   <= 6'b111110;
      end else begin
        r_row_idx <= r_row_idx + 3'd1;
        r_row_n   <= {r_row_n[4:0], 1'b1};
      end
    end else begin
      r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
    end
  end

  assign row_n = r_row_n;

  // --------------------------------------------------------------------------
  // Frame classification
  // --------------------------------------------------------------------------
  logic [3:0] w_low;
  logic [2:0] w_row_lows;
  logic [1:0] w_col_idx;
  logic [4:0] w_row_key;
  logic [2:0] w_total;
  logic [4:0] w_frame_key;
  logic       w_none;
  logic       w_single;
  logic [1:0] r_hits;   // lows seen so far this frame, saturating at 2
  logic [4:0] r_key;    // position of the most recent single low

  assign w_low      = ~r_col_sync;
  assign w_row_lows = {2'b00, w_low[0]} + {2'b00, w_low[1]}
                    + {2'b00, w_low[2]} + {2'b00, w_low[3]};

  // Only meaningful when exactly one column is low in this row.
  always_comb begin
    w_col_idx = 2'd0;
    if (w_low[3]) w_col_idx = 2'd3;
    if (w_low[2]) w_col_idx = 2'd2;
    if (w_low[1]) w_col_idx = 2'd1;
    if (w_low[0]) w_col_idx = 2'd0;
  end

  assign w_row_key   = {r_row_idx, w_col_idx};
  // The row-5 sample is folded in combinationally so the frame verdict is
  // available on the same cycle the frame ends.
  assign w_total     = {1'b0, r_hits} + w_row_lows;
  assign w_frame_key = (w_row_lows == 3'd1) ? w_row_key : r_key;
  assign w_none      = (w_total == 3'd0);
  assign w_single    = (w_total == 3'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hits <= 2'd0;
      r_key  <= 5'd0;
    end else if (w_frame_end) begin
      r_hits <= 2'd0;
      r_key  <= 5'd0;
    end else if (w_sample) begin
      r_hits <= (w_total >= 3'd2) ? 2'd2 : w_total[1:0];
      if (w_row_lows == 3'd1) begin
        r_key <= w_row_key;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nx;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nx;
  logic [c_CNT_W-1:0] w_cnt_inc;
  logic [4:0]         r_cand;
  logic [4:0]         w_cand_nx;
  logic               w_accept;
  logic               w_release;

  // Saturating increment: the counter parks at DEBOUNCE_SCANS, never wraps.
  assign w_cnt_inc = (r_cnt >= c_CNT_SAT) ? c_CNT_SAT : (r_cnt + c_CNT_W'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cand  <= 5'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_cand  <= w_cand_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cand_nx  = r_cand;
    w_accept   = 1'b0;
    w_release  = 1'b0;
    if (w_frame_end) begin
      case (r_state)
        ST_IDLE: begin
          if (w_single) begin
            w_cand_nx  = w_frame_key;
            w_cnt_nx   = c_CNT_W'(1);
            w_state_nx = ST_DEB_PRESS;
          end
        end
        ST_DEB_PRESS: begin
          if (w_single && (w_frame_key == r_cand)) begin
            if (w_cnt_inc == c_CNT_SAT) begin
              w_accept   = 1'b1;
              w_cnt_nx   = '0;
              w_state_nx = ST_HELD;
            end else begin
              w_cnt_nx = w_cnt_inc;
            end
          end else begin
            w_cnt_nx   = '0;
            w_state_nx = ST_IDLE;
          end
        end
        ST_HELD: begin
          // Extra or different keys while held are ignored: no rollover.
          if (w_none) begin
            w_cnt_nx   = c_CNT_W'(1);
            w_state_nx = ST_DEB_RELEASE;
          end
        end
        ST_DEB_RELEASE: begin
          if (w_none) begin
            if (w_cnt_inc == c_CNT_SAT) begin
              w_release  = 1'b1;
              w_cnt_nx   = '0;
              w_state_nx = ST_IDLE;
            end else begin
              w_cnt_nx = w_cnt_inc;
            end
          end else begin
            w_cnt_nx   = '0;
            w_state_nx = ST_HELD;
          end
        end
        default: begin
          w_cnt_nx   = '0;
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  logic       r_newkey;
  logic [4:0] r_keycode;
  logic       r_key_held;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_newkey   <= 1'b0;
      r_keycode  <= 5'b00000;
      r_key_held <= 1'b0;
    end else begin
      r_newkey <= w_accept;
      if (w_accept) begin
        r_keycode  <= f_keymap(r_cand);
        r_key_held <= 1'b1;
      end else if (w_release) begin
        r_key_held <= 1'b0;
      end
    end
  end

  assign newkey   = r_newkey;
  assign keycode  = r_keycode;
  assign key_held = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_keypad_scanner                                            |
// | Description : Directed self-checking bench for keypad_scanner with         |
// |               SCAN_DIV=4, DEBOUNCE_SCANS=3 (24-cycle frames). A behavioural|
// |               key matrix drives col_n from row_n; expected keycodes are    |
// |               queued when a press is driven and popped on every newkey.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_keypad_scanner;

  localparam int c_DIV   = 4;
  localparam int c_DEB   = 3;
  localparam int c_FRAME = 6 * c_DIV;

  logic       clock;
  logic       reset;
  logic [3:0] col_n;
  logic [5:0] row_n;
  logic       newkey;
  logic [4:0] keycode;
  logic       key_held;

  logic [23:0] pressed;     // pressed[4*r+c] = key at row r, column c is down
  logic [4:0]  sb_q[$];     // expected keycodes, in press order
  logic [4:0]  model_kc;    // keycode the bench expects on the output
  logic        prev_nk;
  int          cyc;         // posedges since the last reset release
  int          pulses;
  int          n_cmp;
  int          n_err;

  keypad_scanner #(
    .SCAN_DIV       (c_DIV),
    .DEBOUNCE_SCANS (c_DEB)
  ) u_dut (
    .clock    (clock),
    .reset    (reset),
    .col_n    (col_n),
    .row_n    (row_n),
    .newkey   (newkey),
    .keycode  (keycode),
    .key_held (key_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Passive switch matrix: a pressed key shorts its column to its row.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_n[r] && pressed[4*r+c]) col_n[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Scoreboard monitor: every newkey consumes one queued expectation.
  initial begin
    model_kc = 5'b0;
    prev_nk  = 1'b0;
    pulses   = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        model_kc = 5'b0;
        prev_nk  = 1'b0;
      end else begin
        if (newkey) begin
          pulses++;
          chk("newkey_width", {31'b0, prev_nk}, 32'd0);
          if (sb_q.size() == 0) chk("newkey_unexpected", {31'b0, newkey}, 32'd0);
          else                  model_kc = sb_q.pop_front();
        end
        chk("keycode_model", {27'b0, keycode}, {27'b0, model_kc});
        prev_nk = newkey;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] exp_row;
    n_cmp   = 0;
    n_err   = 0;
    pressed = '0;
    reset   = 1'b0;

    // ---------------- reset state ----------------
    step(3);
    chk("rst_row_n",    {26'b0, row_n},   32'h3E);
    chk("rst_newkey",   {31'b0, newkey},  32'd0);
    chk("rst_keycode",  {27'b0, keycode}, 32'd0);
    chk("rst_key_held", {31'b0, key_held}, 32'd0);
    reset = 1'b1;

    // ---------------- row scan over 3 frames ----------------
    for (int i = 0; i < 3 * c_FRAME; i++) begin
      exp_row = ~(6'd1 << ((cyc / c_DIV) % 6));
      chk("scan_row_n",   {26'b0, row_n}, {26'b0, exp_row});
      chk("scan_onecold", $countones(~row_n), 32'd1);
      step(1);
    end

    // ---------------- digit 8 (r2c1), hold 10 frames ----------------
    pressed[9] = 1'b1;                       // cyc = 72, frame aligned
    sb_q.push_back(5'b11000);
    step(3 * c_FRAME - 1);
    chk("d8_no_early_pulse", {31'b0, newkey}, 32'd0);
    step(1);
    chk("d8_newkey",   {31'b0, newkey},   32'd1);
    chk("d8_keycode",  {27'b0, keycode},  32'b11000);
    chk("d8_key_held", {31'b0, key_held}, 32'd1);
    step(7 * c_FRAME);
    pressed[9] = 1'b0;                       // released after 10 frames
    step(3 * c_FRAME - 1);
    chk("d8_held_before_drop", {31'b0, key_held}, 32'd1);
    step(1);
    chk("d8_held_dropped", {31'b0, key_held}, 32'd0);
    chk("d8_pulses", pulses, 32'd1);

    // ---------------- equals (r5c3) with bounce ----------------
    for (int i = 0; i < 2 * c_FRAME; i++) begin
      if (i % 7 == 0) pressed[23] = ~pressed[23];
      step(1);
    end
    pressed[23] = 1'b1;
    sb_q.push_back(5'b00100);
    step(5 * c_FRAME);
    chk("eq_pulses",   pulses, 32'd2);
    chk("eq_keycode",  {27'b0, keycode},  32'b00100);
    chk("eq_key_held", {31'b0, key_held}, 32'd1);
    pressed[23] = 1'b0;
    step(4 * c_FRAME);
    chk("eq_released", {31'b0, key_held}, 32'd0);

    // ---------------- two-key press: r4c0 + r4c2 ----------------
    pressed[16] = 1'b1;
    pressed[18] = 1'b1;
    step(6 * c_FRAME);
    chk("multi_pulses",   pulses, 32'd2);
    chk("multi_keycode",  {27'b0, keycode},  32'b00100);
    chk("multi_key_held", {31'b0, key_held}, 32'd0);
    pressed[16] = 1'b0;
    pressed[18] = 1'b0;
    step(2 * c_FRAME);

    // ---------------- digit 1 (r0c0), one NONE frame, re-press ----------------
    pressed[0] = 1'b1;                       // cyc = 840, frame aligned
    sb_q.push_back(5'b10001);
    step(4 * c_FRAME);
    chk("d1_pulses",   pulses, 32'd3);
    chk("d1_key_held", {31'b0, key_held}, 32'd1);
    pressed[0] = 1'b0;
    step(c_FRAME);
    pressed[0] = 1'b1;
    step(4 * c_FRAME);
    chk("d1_still_held",  {31'b0, key_held}, 32'd1);
    chk("d1_no_repulse",  pulses, 32'd3);
    chk("d1_keycode",     {27'b0, keycode}, 32'b10001);
    pressed[0] = 1'b0;
    step(4 * c_FRAME);
    chk("d1_released", {31'b0, key_held}, 32'd0);

    // ---------------- reset mid-debounce of F (r3c1) ----------------
    pressed[13] = 1'b1;                      // frame aligned
    step(2 * c_FRAME + 10);                  // two matching frames, mid third
    reset = 1'b0;
    #1;
    chk("mid_rst_row_n",   {26'b0, row_n},   32'h3E);
    chk("mid_rst_newkey",  {31'b0, newkey},  32'd0);
    chk("mid_rst_keycode", {27'b0, keycode}, 32'd0);
    step(3);
    reset = 1'b1;
    sb_q.push_back(5'b11111);
    step(3 * c_FRAME - 1);
    chk("f_no_early_pulse", {31'b0, newkey}, 32'd0);
    step(1);
    chk("f_newkey",   {31'b0, newkey},   32'd1);
    chk("f_keycode",  {27'b0, keycode},  32'b11111);
    chk("f_key_held", {31'b0, key_held}, 32'd1);
    pressed[13] = 1'b0;
    step(4 * c_FRAME);
    chk("f_released", {31'b0, key_held}, 32'd0);

    // ---------------- wrap-up ----------------
    chk("total_pulses", pulses, 32'd4);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
